// File: rtl/bec_key_feeder_if.sv
// Core-side bus of the key feeder.
// master: feeder side. It drives enable, the current key bit and the
//         registered operand copies, and receives the iteration pulses
//         and the result words.
// slave : scalar-multiplication core side.
interface bec_key_feeder_if #(
  parameter int DATA_W = 163
);
  logic              enable;
  logic              ki;
  logic [DATA_W-1:0] w1;
  logic [DATA_W-1:0] z1;
  logic [DATA_W-1:0] w2;
  logic [DATA_W-1:0] z2;
  logic [DATA_W-1:0] d;
  logic [DATA_W-1:0] inv_w0;
  logic              next_key;
  logic              done;
  logic [DATA_W-1:0] wout;
  logic [DATA_W-1:0] zout;

  modport master (
    output enable, ki, w1, z1, w2, z2, d, inv_w0,
    input  next_key, done, wout, zout
  );

  modport slave (
    input  enable, ki, w1, z1, w2, z2, d, inv_w0,
    output next_key, done, wout, zout
  );
endinterface

// File: rtl/bec_key_feeder.sv
// Key feeder for a 163-bit binary-Edwards scalar-multiplication core.
// The feeder latches a scalar and the curve operands on start. It then
// presents the key MSB-first to the core, one bit per ladder iteration,
// and checks the pulse protocol of the core. It captures the result
// and holds it until the host acknowledges it.
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   start, abort      host launch / cancel
//   key, w1..inv_w0   scalar and operands, sampled on an accepted start
//   busy, iter        run status and count of consumed key bits
//   res_valid/res_ack result handshake; res_w/res_z captured result
//   err               protocol or timeout error, held until abort/reset
//   core              bus to the core (bec_key_feeder_if.master)
module bec_key_feeder #(
  parameter  int TIMEOUT_CYCLES = 4096,
  localparam int DATA_W         = 163
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] key,
  input  logic [DATA_W-1:0] w1,
  input  logic [DATA_W-1:0] z1,
  input  logic [DATA_W-1:0] w2,
  input  logic [DATA_W-1:0] z2,
  input  logic [DATA_W-1:0] d,
  input  logic [DATA_W-1:0] inv_w0,
  output logic              busy,
  output logic              res_valid,
  input  logic              res_ack,
  output logic [DATA_W-1:0] res_w,
  output logic [DATA_W-1:0] res_z,
  output logic              err,
  output logic [7:0]        iter,
  bec_key_feeder_if.master  core
);

  localparam int       TW   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    LAST = 8'd162;

  typedef enum logic [1:0] {IDLE, RUN, HOLD, ERR} state_t;

  state_t            state_q, state_nxt;
  logic [DATA_W-1:0] key_sh;
  logic [DATA_W-1:0] w1_q, z1_q, w2_q, z2_q, d_q, inv_w0_q;
  logic [DATA_W-1:0] res_w_q, res_z_q;
  logic [7:0]        iter_q;
  logic [TW-1:0]     tcnt_q;
  logic              load, shift, capture, clr_iter, tcnt_clr, tcnt_inc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_nxt;
  end

  // abort overrides every other event in the same cycle, in every state
  always_comb begin
    state_nxt = state_q;
    load      = 1'b0;
    shift     = 1'b0;
    capture   = 1'b0;
    clr_iter  = 1'b0;
    tcnt_clr  = 1'b0;
    tcnt_inc  = 1'b0;
    if (abort) begin
      state_nxt = IDLE;
      clr_iter  = 1'b1;
      tcnt_clr  = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            load      = 1'b1;
            state_nxt = RUN;
          end
        end
        RUN: begin
          if (core.done) begin
            // done is legal only together with the final (163rd) iteration
            if (iter_q == LAST) begin
              capture   = 1'b1;
              state_nxt = HOLD;
            end else begin
              state_nxt = ERR;
            end
          end else if (core.next_key) begin
            if (iter_q == LAST) begin
              state_nxt = ERR;
            end else begin
              shift    = 1'b1;
              tcnt_clr = 1'b1;
            end
          end else if (tcnt_q == TMAX) begin
            state_nxt = ERR;
          end else begin
            tcnt_inc = 1'b1;
          end
        end
        HOLD: begin
          if (res_ack) state_nxt = IDLE;
        end
        ERR: begin
          state_nxt = ERR;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_sh   <= '0;
      w1_q     <= '0;
      z1_q     <= '0;
      w2_q     <= '0;
      z2_q     <= '0;
      d_q      <= '0;
      inv_w0_q <= '0;
      res_w_q  <= '0;
      res_z_q  <= '0;
      iter_q   <= '0;
      tcnt_q   <= '0;
    end else begin
      if (load) begin
        key_sh   <= key;
        w1_q     <= w1;
        z1_q     <= z1;
        w2_q     <= w2;
        z2_q     <= z2;
        d_q      <= d;
        inv_w0_q <= inv_w0;
        iter_q   <= '0;
      end else if (shift) begin
        key_sh <= {key_sh[DATA_W-2:0], 1'b0};
        iter_q <= iter_q + 8'd1;
      end else if (clr_iter) begin
        iter_q <= '0;
      end
      if (load || tcnt_clr)  tcnt_q <= '0;
      else if (tcnt_inc)     tcnt_q <= tcnt_q + TW'(1);
      // the result registers keep their value after HOLD until the next capture
      if (capture) begin
        res_w_q <= core.wout;
        res_z_q <= core.zout;
      end
    end
  end

  assign busy        = (state_q == RUN);
  assign res_valid   = (state_q == HOLD);
  assign err         = (state_q == ERR);
  assign iter        = iter_q;
  assign res_w       = res_w_q;
  assign res_z       = res_z_q;
  assign core.enable = (state_q == RUN);
  assign core.ki     = key_sh[DATA_W-1];
  assign core.w1     = w1_q;
  assign core.z1     = z1_q;
  assign core.w2     = w2_q;
  assign core.z2     = z2_q;
  assign core.d      = d_q;
  assign core.inv_w0 = inv_w0_q;

endmodule

// File: tb/tb_bec_key_feeder.sv
// Testbench for bec_key_feeder. A core model drives ladder pulses. The
// expected key bit for iteration i is key[162-i] of the scalar that
// the host launched.
module tb_bec_key_feeder;
  logic         clk = 1'b0;
  logic         rst, start, abort, res_ack;
  logic [162:0] key, w1, z1, w2, z2, d, inv_w0;
  logic         busy, res_valid, err;
  logic [162:0] res_w, res_z;
  logic [7:0]   iter;

  logic [162:0] ew1, ez1, ew2, ez2, ed, einv;
  int           exp_iter;
  int           checks = 0;
  int           errors = 0;

  bec_key_feeder_if #(.DATA_W(163)) cif();

  bec_key_feeder #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .key(key),
    .w1(w1), .z1(z1), .w2(w2), .z2(z2), .d(d), .inv_w0(inv_w0),
    .busy(busy), .res_valid(res_valid), .res_ack(res_ack),
    .res_w(res_w), .res_z(res_z), .err(err), .iter(iter), .core(cif)
  );

  always #5 clk = ~clk;

  function automatic logic [162:0] rand163();
    logic [191:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return t[162:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // launch a run from IDLE and check the operand copies handed to the core
  task automatic start_run(input logic [162:0] k);
    ew1 = rand163(); ez1 = rand163(); ew2 = rand163();
    ez2 = rand163(); ed = rand163(); einv = rand163();
    w1 = ew1; z1 = ez1; w2 = ew2; z2 = ez2; d = ed; inv_w0 = einv;
    key = k; start = 1'b1;
    step();
    start = 1'b0; key = rand163();
    w1 = rand163(); z1 = rand163(); w2 = rand163();
    z2 = rand163(); d = rand163(); inv_w0 = rand163();
    exp_iter = 0;
    checks++;
    if (busy !== 1'b1 || cif.enable !== 1'b1 || iter !== 8'd0) begin
      errors++;
      $display("FAIL start: busy=%b en=%b iter=%0d, required 1 1 0", busy, cif.enable, iter);
    end
    checks++;
    if ({cif.w1, cif.z1, cif.w2} !== {ew1, ez1, ew2}) begin
      errors++;
      $display("FAIL operands_a: got %h required %h", cif.w1, ew1);
    end
    checks++;
    if ({cif.z2, cif.d, cif.inv_w0} !== {ez2, ed, einv}) begin
      errors++;
      $display("FAIL operands_b: got %h required %h", cif.inv_w0, einv);
    end
  endtask

  // n ladder iterations; gap=0 gives random spacing, otherwise a fixed period
  task automatic pulses(input logic [162:0] k, input int n, input int gap);
    int idle;
    for (int p = 0; p < n; p++) begin
      idle = (gap > 0) ? gap - 1 : int'($urandom_range(0, 8));
      for (int c = 0; c < idle; c++) begin
        start = 1'($urandom_range(0, 1));
        key = rand163();
        step();
        checks++;
        if (busy !== 1'b1 || cif.enable !== 1'b1 || err !== 1'b0) begin
          errors++;
          $display("FAIL run_idle: busy=%b en=%b err=%b at iter %0d, required 1 1 0", busy, cif.enable, err, exp_iter);
        end
      end
      start = 1'b0;
      checks++;
      if (cif.ki !== k[162-exp_iter]) begin
        errors++;
        $display("FAIL ki: iter %0d got %b required %b", exp_iter, cif.ki, k[162-exp_iter]);
      end
      checks++;
      if (iter !== 8'(exp_iter)) begin
        errors++;
        $display("FAIL iter: got %0d required %0d", iter, exp_iter);
      end
      cif.next_key = 1'b1;
      step();
      cif.next_key = 1'b0;
      exp_iter++;
    end
  endtask

  // final iteration with done, then a few HOLD cycles with ignored starts
  task automatic finish_run(input logic [162:0] k, input logic [162:0] wo, input logic [162:0] zo);
    int hold;
    checks++;
    if (cif.ki !== k[0] || iter !== 8'd162) begin
      errors++;
      $display("FAIL last_iter: ki=%b iter=%0d required %b 162", cif.ki, iter, k[0]);
    end
    cif.next_key = 1'b1; cif.done = 1'b1; cif.wout = wo; cif.zout = zo;
    step();
    cif.next_key = 1'b0; cif.done = 1'b0; cif.wout = rand163(); cif.zout = rand163();
    checks++;
    if (res_valid !== 1'b1 || busy !== 1'b0 || cif.enable !== 1'b0 || err !== 1'b0 || iter !== 8'd162) begin
      errors++;
      $display("FAIL capture: valid=%b busy=%b en=%b err=%b iter=%0d, required 1 0 0 0 162",
               res_valid, busy, cif.enable, err, iter);
    end
    checks++;
    if (res_w !== wo || res_z !== zo) begin
      errors++;
      $display("FAIL result: w=%h z=%h required w=%h z=%h", res_w, res_z, wo, zo);
    end
    hold = int'($urandom_range(1, 4));
    for (int c = 0; c < hold; c++) begin
      start = 1'b1; key = rand163();
      step();
      checks++;
      if (res_valid !== 1'b1 || busy !== 1'b0 || res_w !== wo || res_z !== zo) begin
        errors++;
        $display("FAIL hold: valid=%b busy=%b w=%h, required 1 0 %h", res_valid, busy, res_w, wo);
      end
    end
    start = 1'b0;
  endtask

  task automatic ack(input logic with_start, input logic [162:0] wo);
    res_ack = 1'b1; start = with_start; key = rand163();
    step();
    res_ack = 1'b0; start = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || cif.enable !== 1'b0 || res_w !== wo) begin
      errors++;
      $display("FAIL ack: valid=%b busy=%b en=%b w=%h, required 0 0 0 %h", res_valid, busy, cif.enable, res_w, wo);
    end
    step();
    checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL ack_idle: busy=%b valid=%b, required 0 0", busy, res_valid);
    end
  endtask

  task automatic do_abort();
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if (err !== 1'b0 || busy !== 1'b0 || iter !== 8'd0 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort: err=%b busy=%b iter=%0d valid=%b, required 0 0 0 0", err, busy, iter, res_valid);
    end
  endtask

  task automatic full_run(input logic [162:0] k, input int gap);
    logic [162:0] wo, zo;
    wo = rand163(); zo = rand163();
    start_run(k);
    pulses(k, 162, gap);
    finish_run(k, wo, zo);
    ack(1'b0, wo);
  endtask

  task automatic test_reset();
    checks++;
    if ({busy, res_valid, err, cif.enable, cif.ki} !== 5'b0 || iter !== 8'd0) begin
      errors++;
      $display("FAIL reset_ctrl: busy=%b valid=%b err=%b en=%b ki=%b iter=%0d, required all 0",
               busy, res_valid, err, cif.enable, cif.ki, iter);
    end
    checks++;
    if ({res_w, res_z, cif.w1, cif.inv_w0} !== '0) begin
      errors++;
      $display("FAIL reset_data: res_w=%h w1=%h, required 0", res_w, cif.w1);
    end
  endtask

  task automatic test_zero_key();
    logic [162:0] wo, zo;
    wo = {41{4'h5, 4'hA}};
    zo = {41{4'h3, 4'hC}};
    start_run('0);
    pulses('0, 162, 7);
    finish_run('0, wo, zo);
    ack(1'b0, wo);
    checks++;
    if (res_z !== zo) begin
      errors++;
      $display("FAIL retain: z=%h required %h", res_z, zo);
    end
  endtask

  task automatic test_edge_key();
    logic [162:0] k;
    k = '0; k[162] = 1'b1; k[0] = 1'b1;
    full_run(k, 0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) full_run(rand163(), 0);
  endtask

  task automatic test_timeout();
    start_run(rand163());
    repeat (15) step();
    checks++;
    if (err !== 1'b0 || cif.enable !== 1'b1) begin
      errors++;
      $display("FAIL timeout_early: err=%b en=%b after 15 cycles, required 0 1", err, cif.enable);
    end
    step();
    checks++;
    if (err !== 1'b1 || cif.enable !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout: err=%b en=%b busy=%b after 16 cycles, required 1 0 0", err, cif.enable, busy);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL err_sticky: err=%b busy=%b, required 1 0", err, busy);
    end
    do_abort();
  endtask

  task automatic test_abort();
    logic [162:0] k;
    k = rand163();
    start_run(k);
    pulses(k, 50, 0);
    checks++;
    if (iter !== 8'd50) begin
      errors++;
      $display("FAIL iter50: got %0d required 50", iter);
    end
    cif.next_key = 1'b1;
    do_abort();
    cif.next_key = 1'b0;
    full_run(rand163(), 0);
  endtask

  task automatic test_bad_done();
    logic [162:0] k, wo;
    k = rand163();
    wo = res_w;
    start_run(k);
    pulses(k, 10, 0);
    cif.done = 1'b1;
    step();
    cif.done = 1'b0;
    checks++;
    if (err !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0 || res_w !== wo) begin
      errors++;
      $display("FAIL early_done: err=%b valid=%b busy=%b, required 1 0 0", err, res_valid, busy);
    end
    do_abort();
    // ack and start together in HOLD must not launch a new run
    k = rand163();
    wo = rand163();
    start_run(k);
    pulses(k, 162, 0);
    finish_run(k, wo, rand163());
    ack(1'b1, wo);
  endtask

  task automatic test_late_next();
    logic [162:0] k;
    k = rand163();
    start_run(k);
    pulses(k, 162, 2);
    cif.next_key = 1'b1;
    step();
    cif.next_key = 1'b0;
    checks++;
    if (err !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL extra_next: err=%b valid=%b busy=%b, required 1 0 0", err, res_valid, busy);
    end
    do_abort();
  endtask

  task automatic test_async_reset();
    logic [162:0] k;
    k = rand163();
    start_run(k);
    pulses(k, 80, 0);
    checks++;
    if (iter !== 8'd80) begin
      errors++;
      $display("FAIL iter80: got %0d required 80", iter);
    end
    #2 rst = 1'b0;
    #1;
    test_reset();
    #3 rst = 1'b1;
    k = rand163();
    start_run(k);
    pulses(k, 162, 0);
    finish_run(k, rand163(), rand163());
    ack(1'b0, res_w);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; res_ack = 1'b0;
    key = '0; w1 = '0; z1 = '0; w2 = '0; z2 = '0; d = '0; inv_w0 = '0;
    cif.next_key = 1'b0; cif.done = 1'b0; cif.wout = '0; cif.zout = '0;
    exp_iter = 0;
    repeat (3) step();
    test_reset();
    #2 rst = 1'b1;
    step();
    test_reset();
    test_zero_key();
    test_edge_key();
    test_random();
    test_timeout();
    test_abort();
    test_bad_done();
    test_late_next();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
